cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead add/subtract unit for wide datapaths, such as HI/LO accumulation and multiplier partial-sum reduction.
- The operand is split into SEG-bit lookahead segments, and each pipeline stage resolves one segment, so the critical path is one segment wide whatever WIDTH is.
- It adds a valid/ready handshake with back-pressure, a subtract mode, carry-out and signed overflow, none of which the fixed-width combinational adder has.

---
 rtl/cla_pipe_adder.sv | 145 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/subtract unit: one SEG-bit segment is resolved per
// stage, with a valid/ready handshake and a single global stall enable.
module cla_pipe_adder #(
    parameter int WIDTH = 68,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = (WIDTH + SEG - 1) / SEG;

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;

    // The whole pipeline moves as one unit; it only freezes when the result is parked.
    assign en_s      = !out_valid || out_ready;
    assign in_ready  = en_s;
    assign b_eff_s   = b ^ {WIDTH{sub}};
    assign cin_eff_s = sub | cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int HI = (LO + SEG < WIDTH) ? (LO + SEG) : WIDTH;
        localparam int SW = HI - LO;
        localparam int GW = ((SW + 3) / 4) * 4;

        logic [WIDTH-LO-1:0] pa_in_s;
        logic [WIDTH-LO-1:0] pb_in_s;
        logic                c_in_s;
        logic                v_in_s;
        logic [HI-1:0]       sum_nxt_s;
        logic [SW:0]         carry_s;
        logic [SW-1:0]       seg_sum_s;

        logic                valid_r;
        logic [HI-1:0]       sum_r;
        logic                carry_r;

        // Carries c[i] into each bit of the segment (c[SW] is the segment carry-out),
        // built from 4-bit generate/propagate groups; the segment is zero-padded to a
        // whole number of groups.
        function automatic logic [SW:0] seg_carries(
            input logic [SW-1:0] x,
            input logic [SW-1:0] y,
            input logic          ci
        );
            logic [GW-1:0] g;
            logic [GW-1:0] p;
            logic [GW:0]   c;
            logic          gen;
            logic          prp;
            g           = '0;
            p           = '0;
            g[SW-1:0]   = x & y;
            p[SW-1:0]   = x ^ y;
            c           = '0;
            c[0]        = ci;
            for (int grp = 0; grp < GW / 4; grp++) begin
                gen = 1'b0;
                prp = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    gen              = g[grp*4+i] | (p[grp*4+i] & gen);
                    prp              = p[grp*4+i] & prp;
                    c[grp*4+i+1]     = gen | (prp & c[grp*4]);
                end
            end
            return c[SW:0];
        endfunction

        if (k == 0) begin : g_src
            assign pa_in_s   = a;
            assign pb_in_s   = b_eff_s;
            assign c_in_s    = cin_eff_s;
            assign v_in_s    = in_valid;
            assign sum_nxt_s = seg_sum_s;
        end else begin : g_src
            assign pa_in_s   = g_stage[k-1].g_pend.pa_r;
            assign pb_in_s   = g_stage[k-1].g_pend.pb_r;
            assign c_in_s    = g_stage[k-1].carry_r;
            assign v_in_s    = g_stage[k-1].valid_r;
            assign sum_nxt_s = {seg_sum_s, g_stage[k-1].sum_r};
        end

        assign carry_s   = seg_carries(pa_in_s[SW-1:0], pb_in_s[SW-1:0], c_in_s);
        assign seg_sum_s = pa_in_s[SW-1:0] ^ pb_in_s[SW-1:0] ^ carry_s[SW-1:0];

        // Stage state: valid bit, the low sum bits resolved so far, and the segment carry.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_r <= 1'b0;
                sum_r   <= '0;
                carry_r <= 1'b0;
            end else if (en_s) begin
                valid_r <= v_in_s;
                sum_r   <= sum_nxt_s;
                carry_r <= carry_s[SW];
            end
        end

        if (k < NSEG - 1) begin : g_pend
            logic [WIDTH-HI-1:0] pa_r;
            logic [WIDTH-HI-1:0] pb_r;

            // Operand bits above this segment ride along until their own stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pa_r <= '0;
                    pb_r <= '0;
                end else if (en_s) begin
                    pa_r <= pa_in_s[WIDTH-LO-1:SW];
                    pb_r <= pb_in_s[WIDTH-LO-1:SW];
                end
            end
        end else begin : g_last
            logic ovf_r;

            // Signed overflow: carry into the MSB differs from the carry out of it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (en_s) begin
                    ovf_r <= carry_s[SW-1] ^ carry_s[SW];
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].valid_r;
    assign sum       = g_stage[NSEG-1].sum_r;
    assign cout      = g_stage[NSEG-1].carry_r;
    assign ovf       = g_stage[NSEG-1].g_last.ovf_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and streaming checks of cla_pipe_adder against an arithmetic reference model.
module tb_cla_pipe_adder;
    localparam int W = 68;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic         s_valid;
    logic [19:0]  sa;
    logic [19:0]  sb;
    logic         s_cin;
    logic         s_sub;
    logic         s_out_ready;
    logic         s8_in_ready;
    logic         s8_out_valid;
    logic [19:0]  s8_sum;
    logic         s8_cout;
    logic         s8_ovf;
    logic         s32_in_ready;
    logic         s32_out_valid;
    logic [19:0]  s32_sum;
    logic         s32_cout;
    logic         s32_ovf;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic         hold_pend = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_c;
    logic         hold_o;

    cla_pipe_adder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_pipe_adder #(.WIDTH(20), .SEG(8)) u_w20s8 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s8_in_ready),
        .a(sa), .b(sb), .cin(s_cin), .sub(s_sub),
        .out_valid(s8_out_valid), .out_ready(s_out_ready),
        .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf)
    );

    cla_pipe_adder #(.WIDTH(20), .SEG(32)) u_w20s32 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s32_in_ready),
        .a(sa), .b(sb), .cin(s_cin), .sub(s_sub),
        .out_valid(s32_out_valid), .out_ready(s_out_ready),
        .sum(s32_sum), .cout(s32_cout), .ovf(s32_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, no carry chains.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic s,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0]          wide;
        logic signed [W+1:0] sv;
        logic signed [W+1:0] sx;
        logic signed [W+1:0] sy;
        sx = $signed({{2{x[W-1]}}, x});
        sy = $signed({{2{y[W-1]}}, y});
        if (s) begin
            r  = x - y;
            co = (x >= y);
            sv = sx - sy;
        end else begin
            wide = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            r    = wide[W-1:0];
            co   = wide[W];
            sv   = sx + sy + {{(W+1){1'b0}}, c};
        end
        ov = !((sv[W+1:W-1] == 3'b000) || (sv[W+1:W-1] == 3'b111));
    endfunction

    always @(posedge rst) begin
        exp_q.delete();
        hold_pend = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", W'(out_valid), W'(1'b1));
                check("hold_sum", sum, hold_sum);
                check("hold_cout", W'(cout), W'(hold_c));
                check("hold_ovf", W'(ovf), W'(hold_o));
            end
            check("in_ready", W'(in_ready), W'(!out_valid || out_ready));
            if (in_valid && in_ready) begin
                model(a, b, cin, sub, mon_e.s, mon_e.c, mon_e.o);
                exp_q.push_back(mon_e);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", W'(out_valid), W'(1'b0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("model_sum", sum, mon_e.s);
                    check("model_cout", W'(cout), W'(mon_e.c));
                    check("model_ovf", W'(ovf), W'(mon_e.o));
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_sum  = sum;
            hold_c    = cout;
            hold_o    = ovf;
        end
    end

    // Called at #1 after a rising edge with the pipeline drained.
    task automatic run_one(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc, input logic ts,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        cin       = tc;
        sub       = ts;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_lat"}, W'(lat), W'(5));
        check({nm, "_sum"}, sum, es);
        check({nm, "_cout"}, W'(cout), W'(ec));
        check({nm, "_ovf"}, W'(ovf), W'(eo));
        @(posedge clk); #1;
    endtask

    task automatic run_small(input string nm, input logic [19:0] ta, input logic [19:0] tb_v,
                             input logic [19:0] es, input logic ec, input logic eo);
        int l8;
        int l32;
        s_valid = 1'b1;
        sa      = ta;
        sb      = tb_v;
        @(posedge clk); #1;
        s_valid = 1'b0;
        l8  = 0;
        l32 = 0;
        for (int i = 1; i <= 10; i++) begin
            if (s8_out_valid && l8 == 0) begin
                l8 = i;
                check({nm, "_s8_sum"}, W'(s8_sum), W'(es));
                check({nm, "_s8_cout"}, W'(s8_cout), W'(ec));
                check({nm, "_s8_ovf"}, W'(s8_ovf), W'(eo));
            end
            if (s32_out_valid && l32 == 0) begin
                l32 = i;
                check({nm, "_s32_sum"}, W'(s32_sum), W'(es));
                check({nm, "_s32_cout"}, W'(s32_cout), W'(ec));
            end
            @(posedge clk); #1;
        end
        check({nm, "_s8_lat"}, W'(l8), W'(3));
        check({nm, "_s32_lat"}, W'(l32), W'(1));
    endtask

    initial begin
        int          sent;
        int          cyc;
        int          seen;
        logic        acc;
        logic [95:0] r96;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        s_valid = 1'b0; sa = '0; sb = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
        #12;
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_sum", sum, '0);
        check("rst_cout", W'(cout), W'(1'b0));
        check("rst_ovf", W'(ovf), W'(1'b0));
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_one("ripple", 68'hF_FFFF_FFFF_FFFF_FFFF, 68'd1, 1'b0, 1'b0, 68'd0, 1'b1, 1'b0);
        run_one("sub5m7", 68'd5, 68'd7, 1'b0, 1'b1, 68'hF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_one("sub7m5", 68'd7, 68'd5, 1'b0, 1'b1, 68'd2, 1'b1, 1'b0);
        run_one("ovf_add", 68'h7_FFFF_FFFF_FFFF_FFFF, 68'd1, 1'b0, 1'b0,
                68'h8_0000_0000_0000_0000, 1'b0, 1'b1);
        run_one("ovf_sub", 68'h8_0000_0000_0000_0000, 68'd1, 1'b0, 1'b1,
                68'h7_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_one("cin_add", 68'd0, 68'd0, 1'b1, 1'b0, 68'd1, 1'b0, 1'b0);
        run_one("cin_sub", 68'd3, 68'd1, 1'b1, 1'b1, 68'd2, 1'b1, 1'b0);
        run_one("seg_edge", 68'h0_0000_0000_0000_FFFF, 68'd1, 1'b0, 1'b0, 68'h1_0000, 1'b0, 1'b0);

        // Streaming with a three-cycle consumer stall in the middle.
        sent = 0;
        cyc  = 0;
        in_valid = 1'b1;
        r96 = {$urandom, $urandom, $urandom}; a = r96[W-1:0];
        r96 = {$urandom, $urandom, $urandom}; b = r96[W-1:0];
        cin = 1'(($urandom_range(0, 1))); sub = 1'(($urandom_range(0, 1)));
        while (sent < 10 && cyc < 200) begin
            out_ready = !(cyc >= 6 && cyc < 9);
            @(negedge clk);
            if (cyc == 6) check("bp_in_ready_drop", W'(in_ready), W'(1'b0));
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 10) begin
                    r96 = {$urandom, $urandom, $urandom}; a = r96[W-1:0];
                    r96 = {$urandom, $urandom, $urandom}; b = r96[W-1:0];
                    cin = 1'(($urandom_range(0, 1))); sub = 1'(($urandom_range(0, 1)));
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_sent", W'(sent), W'(10));
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_drained", W'(exp_q.size()), W'(0));

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'(i + 10); b = W'(i + 1); cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rstfl_out_valid", W'(out_valid), W'(1'b0));
        check("rstfl_in_ready", W'(in_ready), W'(1'b1));
        #3 rst = 1'b0;
        @(posedge clk); #1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("rstfl_none_seen", W'(seen), W'(0));
        run_one("after_rst", 68'd100, 68'd23, 1'b0, 1'b0, 68'd123, 1'b0, 1'b0);

        // Reset while a finished result is parked by back-pressure.
        in_valid = 1'b1; a = 68'hF_FFFF_FFFF_FFFF_FFFF; b = 68'd2; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("park_valid", W'(out_valid), W'(1'b1));
        check("park_sum", sum, 68'd1);
        #2 rst = 1'b1;
        #1;
        check("rstpk_out_valid", W'(out_valid), W'(1'b0));
        check("rstpk_sum", sum, '0);
        check("rstpk_cout", W'(cout), W'(1'b0));
        #3 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        run_small("w20_wrap", 20'hFFFFF, 20'h00001, 20'h00000, 1'b1, 1'b0);
        run_small("w20_ovf", 20'h7FFFF, 20'h00001, 20'h80000, 1'b0, 1'b1);

        check("final_queue_empty", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
